router_pkt_reader: RTL
======================

ROUTER_PKT_READER -- requirements
Module: router_pkt_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, meaning mid-packet empty-stall cycles before abort.
REQ-002 SHALL have parameter CNT_W, default 5, meaning width of the stall counter.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port empty  input  1  router FIFO empty flag.
REQ-006 SHALL have port data_in  input  8  router FIFO data_out; byte is valid one cycle after a read_enb with empty low.
REQ-007 SHALL have port read_enb  output  1  read request to the router FIFO.
REQ-008 SHALL have port soft_reset  output  1  one-cycle pulse that clears the FIFO on timeout.
REQ-009 SHALL have port hdr_valid  output  1  one-cycle pulse when the header is captured.
REQ-010 SHALL have port pkt_addr  output  2  header[1:0], held until the next header.
REQ-011 SHALL have port pkt_len  output  6  header[7:2], held until the next header.
REQ-012 SHALL have port byte_out  output  8  payload byte.
REQ-013 SHALL have port byte_valid  output  1  byte_out holds a payload byte this cycle.
REQ-014 SHALL have port pkt_done  output  1  one-cycle pulse after the parity byte is received.
REQ-015 SHALL have port parity_err  output  1  valid with pkt_done; 1 when the XOR check fails.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, HDR, BODY, DONE and ABORT.
REQ-018 IDLE: read_enb = !empty; on issue, go to HDR.
REQ-019 HDR (header arrives on data_in): latch pkt_len/pkt_addr, pulse hdr_valid, acc = header, need = pkt_len+1 (7-bit: payload + parity), issued = rx = 0; go to BODY.
REQ-020 BODY: read_enb = !empty && (issued < need); this is combinational on empty, never registered.
REQ-021 BODY: each cycle after an issue, count one byte received (rx+1).
REQ-022 BODY: while rx < pkt_len, set byte_out = data_in and byte_valid = 1, and XOR data_in into acc.
REQ-023 BODY: when rx == pkt_len, treat the byte as parity; go to DONE.
REQ-024 DONE: pulse pkt_done, set parity_err = (acc != parity byte); go to IDLE.
REQ-025 DONE: read_enb SHALL be 0, so there is one bubble between packets.
REQ-026 pkt_len = 0: no payload; the first byte in BODY is the parity byte.
REQ-027 The stall counter SHALL increment in BODY on each cycle where a read is needed but empty is high, and clear on any issue.
REQ-028 When the stall counter reaches TIMEOUT, go to ABORT.
REQ-029 ABORT: pulse soft_reset for one cycle, with read_enb = 0 and no pkt_done; return to IDLE.
REQ-030 Never assert read_enb while empty is high.
REQ-031 Never issue more than need reads per packet.
REQ-032 A read issued and a byte received in the same cycle (back-to-back) SHALL both be counted.
REQ-033 hdr_valid, byte_valid, pkt_done and soft_reset SHALL be mutually exclusive in any cycle.

Reset
REQ-034 When resetn is low at a clock edge: state to IDLE; counters, acc, pkt_len, pkt_addr and byte_out to 0; all pulse outputs, parity_err and busy to 0.
REQ-035 Reset SHALL win over every other event, including mid-packet; no pkt_done or soft_reset is emitted for a packet cut by reset.
REQ-036 read_enb SHALL be 0 during reset.

Structure
REQ-037 Package router_pkg SHALL hold the state encoding, the TIMEOUT default and the header field positions (LEN = [7:2], ADDR = [1:0]).
REQ-038 The stall counter SHALL be sub-module router_timeout_ctr (inputs: clock, resetn, clr, inc; output: expired).
REQ-039 All other logic SHALL be in one FSM, with one always block for state/datapath and one for outputs.

Verification
REQ-040 FIFO holds 0x0E,0x11,0x22,0x33,0x0E, empty low -> hdr_valid with addr=2, len=3; byte_valid x3 with 0x11,0x22,0x33; pkt_done=1, parity_err=0.
REQ-041 Same packet with parity byte 0x0F -> pkt_done=1, parity_err=1.
REQ-042 Header 0x01 then parity 0x01 (len=0, addr=1) -> no byte_valid; pkt_done with parity_err=0.
REQ-043 Header 0x0A then one payload byte, then empty held high -> soft_reset pulse exactly 30 cycles after the last issue; state returns to IDLE; no pkt_done.
REQ-044 empty toggles every cycle during a 4-byte payload -> read_enb never high while empty is high; bytes are delivered in order; parity_err=0.
REQ-045 resetn low in the cycle after the 2nd payload byte, then a fresh packet -> all outputs 0 during reset; the new packet decodes correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router packet reader.
// State encoding, timeout default and header field positions.
package router_pkg;

    localparam int TIMEOUT_DEF = 30;
    localparam int CNT_W_DEF   = 5;

    localparam int LEN_HI  = 7;
    localparam int LEN_LO  = 2;
    localparam int ADDR_HI = 1;
    localparam int ADDR_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BODY,
        S_DONE,
        S_ABORT
    } state_t;

    function automatic logic [5:0] hdr_len(input logic [7:0] h);
        return h[LEN_HI:LEN_LO];
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [7:0] h);
        return h[ADDR_HI:ADDR_LO];
    endfunction

endpackage

// File: rtl/router_timeout_ctr.sv
// Mid-packet stall counter for the router packet reader.
// expired fires on the stall cycle that brings the count to TIMEOUT.
module router_timeout_ctr #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // count consecutive stall cycles; any issue or leaving BODY clears
    always_ff @(posedge clock) begin
        if (!resetn || clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = inc && !clr && (r_cnt == LAST);

endmodule

// File: rtl/router_pkt_reader.sv
// Reads header, payload and parity bytes from the router FIFO.
// Decodes the header, streams payload, checks XOR parity, aborts on stall.
module router_pkt_reader
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       empty,
    input  logic [7:0] data_in,
    output logic       read_enb,
    output logic       soft_reset,
    output logic       hdr_valid,
    output logic [1:0] pkt_addr,
    output logic [5:0] pkt_len,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       busy
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_acc;
    logic [6:0] r_need;
    logic [6:0] r_issued;
    logic [6:0] r_rx;
    logic       r_rd_d;
    logic [5:0] r_len;
    logic [1:0] r_addr;
    logic [7:0] r_byte;
    logic       r_bvalid;
    logic       r_hvalid;
    logic       r_perr;

    logic       w_rd;
    logic       w_want;
    logic       w_body;
    logic       w_stall;
    logic       w_clr;
    logic       w_expired;
    logic       w_is_par;

    assign w_body   = (r_state == S_BODY);
    assign w_want   = (r_issued < r_need);
    assign w_stall  = w_body && w_want && empty;
    assign w_clr    = !w_body || w_rd;
    assign w_is_par = w_body && r_rd_d && (r_rx == {1'b0, r_len});

    router_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_tmo (
        .clock   (clock),
        .resetn  (resetn),
        .clr     (w_clr),
        .inc     (w_stall),
        .expired (w_expired)
    );

    // state register and datapath: header latch, counters, parity accumulator
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_need   <= '0;
            r_issued <= '0;
            r_rx     <= '0;
            r_rd_d   <= 1'b0;
            r_len    <= '0;
            r_addr   <= '0;
            r_byte   <= '0;
            r_bvalid <= 1'b0;
            r_hvalid <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rd_d   <= w_rd;
            r_hvalid <= 1'b0;
            r_bvalid <= 1'b0;
            case (r_state)
                S_HDR: begin
                    r_len    <= hdr_len(data_in);
                    r_addr   <= hdr_addr(data_in);
                    r_hvalid <= 1'b1;
                    r_acc    <= data_in;
                    r_need   <= 7'(hdr_len(data_in)) + 7'd1;
                    r_issued <= '0;
                    r_rx     <= '0;
                end
                S_BODY: begin
                    if (w_rd) begin
                        r_issued <= r_issued + 7'd1;
                    end
                    if (r_rd_d) begin
                        r_rx <= r_rx + 7'd1;
                        if (r_rx < {1'b0, r_len}) begin
                            r_byte   <= data_in;
                            r_bvalid <= 1'b1;
                            r_acc    <= r_acc ^ data_in;
                        end else begin
                            r_perr <= (r_acc != data_in);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // next state, read request and status outputs
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_rd = !empty;
                if (!empty) w_next = S_HDR;
            end
            S_HDR: begin
                w_next = S_BODY;
            end
            S_BODY: begin
                w_rd = !empty && w_want;
                if (w_is_par)       w_next = S_DONE;
                else if (w_expired) w_next = S_ABORT;
            end
            S_DONE:  w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (!resetn) w_rd = 1'b0;
    end

    assign read_enb   = w_rd;
    assign busy       = resetn && (r_state != S_IDLE);
    assign pkt_done   = resetn && (r_state == S_DONE);
    assign parity_err = resetn && (r_state == S_DONE) && r_perr;
    assign soft_reset = resetn && (r_state == S_ABORT);
    assign hdr_valid  = resetn && r_hvalid;
    assign byte_valid = resetn && r_bvalid;
    assign pkt_addr   = r_addr;
    assign pkt_len    = r_len;
    assign byte_out   = r_byte;

endmodule
